fir_mac_8: RTL and testbench

Serial multiply-accumulate FIR engine. It sits directly downstream of the 8-tap shift register and consumes its flattened tap bus. On each accepted sample strobe it snapshots the 8 taps and computes sum(tap[i]*coef[i]) over 8 cycles with a single multiplier. It then rounds, saturates and emits one filtered output sample with a valid pulse. Coefficients live in a local 8-entry register bank that is written through a simple write port.

---
 rtl/fir_pkg.sv | 11 +
 rtl/fir_round_sat.sv | 27 ++
 rtl/fir_mac_8.sv | 104 ++++++++++
 tb/tb_fir_mac_8.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: shared constants and state encoding for the serial FIR MAC engines
package fir_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;
    localparam int NTAPS     = 8;
    localparam int ACC_GUARD = 3;
    localparam int IDX_W     = 3;
endpackage

// File: rtl/fir_round_sat.sv
// fir_round_sat: round half toward +inf, arithmetic shift, saturate to OWIDTH
module fir_round_sat #(
    parameter int ACCW   = 35,
    parameter int SHIFT  = 15,
    parameter int OWIDTH = 16
) (
    input  logic signed [ACCW-1:0]   acc,
    output logic signed [OWIDTH-1:0] y,
    output logic                     sat
);
    localparam logic [ACCW:0] ONE = 1;
    localparam logic signed [ACCW:0] RND  = ONE << (SHIFT - 1);
    localparam logic signed [ACCW:0] MAXV = {{(ACCW + 2 - OWIDTH){1'b0}}, {(OWIDTH - 1){1'b1}}};
    localparam logic signed [ACCW:0] MINV = {{(ACCW + 2 - OWIDTH){1'b1}}, {(OWIDTH - 1){1'b0}}};
    logic signed [ACCW:0] sum;
    logic signed [ACCW:0] r;
    logic hi;
    logic lo;
    always_comb begin
        sum = {acc[ACCW-1], acc} + RND;
        r   = sum >>> SHIFT;
        hi  = r > MAXV;
        lo  = r < MINV;
        sat = hi | lo;
        y   = hi ? MAXV[OWIDTH-1:0] : lo ? MINV[OWIDTH-1:0] : r[OWIDTH-1:0];
    end
endmodule

// File: rtl/fir_mac_8.sv
// fir_mac_8: 8-tap serial multiply-accumulate FIR with a writable coefficient bank
module fir_mac_8
    import fir_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int CWIDTH = 16,
    parameter int OWIDTH = 16,
    parameter int SHIFT  = 15
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH*NTAPS-1:0]    taps_flat,
    input  logic                      coef_we,
    input  logic [IDX_W-1:0]          coef_addr,
    input  logic signed [CWIDTH-1:0]  coef_data,
    output logic                      coef_wr_err,
    output logic                      out_valid,
    output logic signed [OWIDTH-1:0]  y,
    output logic                      sat
);
    localparam int ACCW = WIDTH + CWIDTH + ACC_GUARD;

    state_t                     state_q, state_d;
    logic [WIDTH*NTAPS-1:0]     snap_q, snap_d;
    logic signed [CWIDTH-1:0]   coef_q [NTAPS];
    logic signed [CWIDTH-1:0]   coef_d [NTAPS];
    logic signed [ACCW-1:0]     acc_q, acc_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic signed [OWIDTH-1:0]   y_q, y_d, rs_y;
    logic                       sat_q, sat_d, rs_sat;
    logic                       out_valid_q, out_valid_d;
    logic                       coef_wr_err_q, coef_wr_err_d;
    logic                       idle, accept;
    logic signed [WIDTH-1:0]    tap;
    logic signed [WIDTH+CWIDTH-1:0] prod;

    assign idle   = state_q == IDLE;
    assign accept = in_valid & idle;
    assign tap    = snap_q[idx_q*WIDTH +: WIDTH];
    assign prod   = tap * coef_q[idx_q];

    fir_round_sat #(.ACCW(ACCW), .SHIFT(SHIFT), .OWIDTH(OWIDTH)) u_round_sat (
        .acc (acc_q),
        .y   (rs_y),
        .sat (rs_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            snap_q        <= '0;
            coef_q        <= '{default: '0};
            acc_q         <= '0;
            idx_q         <= '0;
            y_q           <= '0;
            sat_q         <= 1'b0;
            out_valid_q   <= 1'b0;
            coef_wr_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            snap_q        <= snap_d;
            coef_q        <= coef_d;
            acc_q         <= acc_d;
            idx_q         <= idx_d;
            y_q           <= y_d;
            sat_q         <= sat_d;
            out_valid_q   <= out_valid_d;
            coef_wr_err_q <= coef_wr_err_d;
        end
    end

    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = accept ? MAC : IDLE;
            MAC:     state_d = idx_q == IDX_W'(NTAPS - 1) ? OUT : MAC;
            default: state_d = IDLE;
        endcase
    end

    // The bank only changes in IDLE, so a running sum always sees one coefficient set.
    always_comb begin
        coef_d = coef_q;
        if (coef_we && idle)
            coef_d[coef_addr] = coef_data;
        snap_d        = accept ? taps_flat : snap_q;
        acc_d         = state_q == MAC ? acc_q + ACCW'(prod) : accept ? '0 : acc_q;
        idx_d         = state_q == MAC ? idx_q + 1'b1 : accept ? '0 : idx_q;
        y_d           = state_q == OUT ? rs_y : y_q;
        sat_d         = state_q == OUT && rs_sat;
        out_valid_d   = state_q == OUT;
        coef_wr_err_d = coef_we && !idle;
    end

    always_comb begin
        in_ready    = idle;
        out_valid   = out_valid_q;
        y           = y_q;
        sat         = sat_q;
        coef_wr_err = coef_wr_err_q;
    end
endmodule

// File: tb/tb_fir_mac_8.sv
// tb_fir_mac_8: randomized scoreboard bench for fir_mac_8 against an arithmetic reference
module tb_fir_mac_8;
    localparam int W = 16;
    localparam int SH = 15;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [W*8-1:0]    taps_flat = '0;
    logic              coef_we = 1'b0;
    logic [2:0]        coef_addr = '0;
    logic signed [W-1:0] coef_data = '0;
    logic              coef_wr_err;
    logic              out_valid;
    logic signed [W-1:0] y;
    logic              sat;

    fir_mac_8 dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .taps_flat(taps_flat), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_data(coef_data), .coef_wr_err(coef_wr_err), .out_valid(out_valid),
        .y(y), .sat(sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint y;
        logic   sat;
        int     cyc;
    } exp_t;

    exp_t   q[$];
    int     checks = 0;
    int     errors = 0;
    int     mcoef[8];
    int     busy = 0;
    int     cyc = 0;
    int     n_acc = 0;
    logic   exp_err = 1'b0;
    longint ymod = 0;
    longint s, r;
    exp_t   e, pe;

    task automatic check(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    // Reference: dot product, floor((sum + 2^(SH-1)) / 2^SH), clamp to output range.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcoef = '{default: 0};
            busy = 0;
            exp_err = 1'b0;
            q.delete();
        end else begin
            cyc++;
            exp_err = coef_we && busy != 0;
            if (busy != 0) busy--;
            else begin
                if (coef_we) mcoef[coef_addr] = int'(coef_data);
                if (in_valid) begin
                    s = 0;
                    for (int i = 0; i < 8; i++)
                        s += longint'($signed(taps_flat[i*W +: W])) * longint'(mcoef[i]);
                    r = (s + (64'sd1 <<< (SH - 1))) >>> SH;
                    pe.sat = r > 32767 || r < -32768;
                    pe.y = r > 32767 ? 32767 : r < -32768 ? -32768 : r;
                    pe.cyc = cyc;
                    q.push_back(pe);
                    busy = 9;
                    n_acc++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n !== 1'b1) ymod = 0;
        else begin
            check("in_ready", longint'(in_ready), longint'(busy == 0));
            check("coef_wr_err", longint'(coef_wr_err), longint'(exp_err));
            if (out_valid) begin
                if (q.size() == 0) check("spurious_out_valid", 1, 0);
                else begin
                    e = q.pop_front();
                    check("latency", longint'(cyc - e.cyc), 9);
                    check("sat", longint'(sat), longint'(e.sat));
                    ymod = e.y;
                end
            end else check("sat_idle", longint'(sat), 0);
            check("y", longint'(y), ymod);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int d);
        coef_we = 1'b1;
        coef_addr = a[2:0];
        coef_data = d[W-1:0];
        tick();
        coef_we = 1'b0;
    endtask

    task automatic set_all(input int d);
        for (int i = 0; i < 8; i++) wr(i, d);
    endtask

    task automatic load(input int t0, input int rest);
        logic [W-1:0] v;
        for (int i = 0; i < 8; i++) begin
            v = (i == 0) ? t0[W-1:0] : rest[W-1:0];
            taps_flat[i*W +: W] = v;
        end
    endtask

    task automatic fire();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (11) tick();
    endtask

    int acc0;

    initial begin
        rst_n = 1'b0;
        repeat (3) tick();
        check("reset_y", longint'(y), 0);
        check("reset_out_valid", longint'(out_valid), 0);
        check("reset_in_ready", longint'(in_ready), 1);
        rst_n = 1'b1;
        tick();
        // impulse
        wr(0, 32767);
        load(16384, 0);
        fire();
        // saturation both ways
        set_all(32767);
        load(32767, 32767);
        fire();
        load(-32768, -32768);
        fire();
        // rounding edges
        set_all(0);
        wr(0, 1);
        load(16384, 0);
        fire();
        wr(0, -1);
        fire();
        wr(0, 1);
        load(16383, 0);
        fire();
        // busy: write at cycle 3 dropped, in_valid at cycle 5 ignored
        wr(0, 32767);
        load(16384, 0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        coef_we = 1'b1; coef_addr = 3'd0; coef_data = 16'sd5;
        tick();
        coef_we = 1'b0;
        tick();
        load(1000, 1000);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (8) tick();
        load(16384, 0);
        fire();
        // write and accept in the same cycle
        coef_we = 1'b1; coef_addr = 3'd0; coef_data = 16'sd8192;
        in_valid = 1'b1;
        tick();
        coef_we = 1'b0; in_valid = 1'b0;
        repeat (11) tick();
        // reset during the 4th MAC cycle
        set_all(1234);
        load(20000, -300);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        check("post_reset_in_ready", longint'(in_ready), 1);
        check("post_reset_y", longint'(y), 0);
        repeat (12) tick();
        load(16384, 16384);
        fire();
        // back-to-back with random taps and coefficients
        for (int i = 0; i < 8; i++) wr(i, int'($urandom_range(0, 65535)) - 32768);
        acc0 = n_acc;
        in_valid = 1'b1;
        for (int c = 0; c < 30; c++) begin
            for (int i = 0; i < 8; i++) taps_flat[i*W +: W] = W'($urandom);
            tick();
        end
        in_valid = 1'b0;
        check("b2b_accepts", longint'(n_acc - acc0), 3);
        repeat (12) tick();
        // random traffic including writes while busy
        for (int c = 0; c < 200; c++) begin
            in_valid = $urandom_range(0, 3) == 0;
            coef_we = $urandom_range(0, 4) == 0;
            coef_addr = 3'($urandom);
            coef_data = W'($urandom);
            for (int i = 0; i < 8; i++) taps_flat[i*W +: W] = W'($urandom);
            tick();
        end
        in_valid = 1'b0;
        coef_we = 1'b0;
        repeat (14) tick();
        check("drain_empty", longint'(q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
